fir_xifu_ex: RTL

- Execute stage of the FIR XIFU. Sits directly downstream of the ID/EX pipe register, which holds one decoded instruction and advances only when `ready_o` = 1.
- Executes the three instructions:
  - xfirlw/xfirsw: issues the XIF memory request and computes the post-incremented base.
  - xfirdotp: 2x int16 dot-product accumulate over 2 cycles.
- Produces a registered EX/WB record for the writeback stage. Reads the XIFU register file, with a bypass from its own EX/WB register.

---
 rtl/fir_xifu_ex.sv | 323 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fir_xifu_ex.sv
// FIR XIFU execute stage: issues XIF load/store requests with post-increment
// base writeback, runs the 2x int16 dot-product accumulate, and holds the
// EX/WB record consumed by the writeback stage.
module fir_xifu_ex #(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned NB_XREGS   = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic [1:0]                  id_instr_i,
  input  logic [31:0]                 id_base_i,
  input  logic [31:0]                 id_offset_i,
  input  logic [$clog2(NB_XREGS)-1:0] id_rs1_i,
  input  logic [$clog2(NB_XREGS)-1:0] id_rs2_i,
  input  logic [$clog2(NB_XREGS)-1:0] id_rd_i,
  input  logic [X_ID_WIDTH-1:0]       id_id_i,
  output logic                        ready_o,
  output logic [$clog2(NB_XREGS)-1:0] rf_raddr_a_o,
  output logic [$clog2(NB_XREGS)-1:0] rf_raddr_b_o,
  output logic [$clog2(NB_XREGS)-1:0] rf_raddr_c_o,
  input  logic [31:0]                 rf_rdata_a_i,
  input  logic [31:0]                 rf_rdata_b_i,
  input  logic [31:0]                 rf_rdata_c_i,
  output logic                        mem_valid_o,
  input  logic                        mem_ready_i,
  output logic [31:0]                 mem_addr_o,
  output logic                        mem_we_o,
  output logic [3:0]                  mem_be_o,
  output logic [31:0]                 mem_wdata_o,
  output logic [X_ID_WIDTH-1:0]       mem_id_o,
  input  logic                        wb_ld_pending_i,
  input  logic [$clog2(NB_XREGS)-1:0] wb_ld_rd_i,
  input  logic                        wb_ready_i,
  output logic                        ex2wb_valid_o,
  output logic [1:0]                  ex2wb_instr_o,
  output logic [X_ID_WIDTH-1:0]       ex2wb_id_o,
  output logic [$clog2(NB_XREGS)-1:0] ex2wb_rd_o,
  output logic                        ex2wb_xrf_we_o,
  output logic [31:0]                 ex2wb_xrf_wdata_o,
  output logic                        ex2wb_core_we_o,
  output logic [$clog2(NB_XREGS)-1:0] ex2wb_core_rd_o,
  output logic [31:0]                 ex2wb_core_wdata_o
);

  localparam int unsigned RW = $clog2(NB_XREGS);

  typedef enum logic [1:0] {
    I_NONE = 2'd0,
    I_LW   = 2'd1,
    I_SW   = 2'd2,
    I_DOTP = 2'd3
  } instr_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_MUL,
    S_WB_WAIT
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [1:0]            instr;
    logic [X_ID_WIDTH-1:0] id;
    logic [RW-1:0]         rd;
    logic                  xrf_we;
    logic [31:0]           xrf_wdata;
    logic                  core_we;
    logic [RW-1:0]         core_rd;
    logic [31:0]           core_wdata;
  } ex2wb_t;

  state_e                r_state;
  ex2wb_t                r_rec;
  logic                  r_kill;
  logic [31:0]           r_p0;
  logic [31:0]           r_p1;
  logic [31:0]           r_acc;
  logic [31:0]           r_res;
  logic [31:0]           r_req_addr;
  logic                  r_req_we;
  logic [31:0]           r_req_wdata;
  logic [X_ID_WIDTH-1:0] r_req_id;

  logic                  w_is_lw;
  logic                  w_is_sw;
  logic                  w_is_dotp;
  logic                  w_is_mem;
  logic                  w_hazard;
  logic [31:0]           w_op_a;
  logic [31:0]           w_op_b;
  logic [31:0]           w_op_c;
  logic [31:0]           w_sw_wdata;
  logic [31:0]           w_a_lo;
  logic [31:0]           w_a_hi;
  logic [31:0]           w_b_lo;
  logic [31:0]           w_b_hi;
  logic [31:0]           w_p0;
  logic [31:0]           w_p1;
  logic [31:0]           w_res;
  logic                  w_req_valid;
  logic [31:0]           w_req_addr;
  logic                  w_req_we;
  logic [31:0]           w_req_wdata;
  logic [X_ID_WIDTH-1:0] w_req_id;
  ex2wb_t                w_rec;
  state_e                w_state_d;
  logic                  w_emit;
  logic                  w_ready;
  logic                  w_clr;
  logic                  w_load_mul;
  logic                  w_load_req;
  logic                  w_store_res;
  logic                  w_kill_d;

  assign w_is_lw   = (id_instr_i == I_LW);
  assign w_is_sw   = (id_instr_i == I_SW);
  assign w_is_dotp = (id_instr_i == I_DOTP);
  assign w_is_mem  = w_is_lw | w_is_sw;

  assign rf_raddr_a_o = id_rs1_i;
  assign rf_raddr_b_o = id_rs2_i;
  assign rf_raddr_c_o = id_rd_i;

  // Operands, bypassed from the EX/WB record when it targets the same XIFU register
  assign w_op_a = (r_rec.valid && r_rec.xrf_we && r_rec.rd == id_rs1_i) ? r_rec.xrf_wdata : rf_rdata_a_i;
  assign w_op_b = (r_rec.valid && r_rec.xrf_we && r_rec.rd == id_rs2_i) ? r_rec.xrf_wdata : rf_rdata_b_i;
  assign w_op_c = (r_rec.valid && r_rec.xrf_we && r_rec.rd == id_rd_i)  ? r_rec.xrf_wdata : rf_rdata_c_i;

  assign w_hazard = wb_ld_pending_i &&
                    ((w_is_dotp && (wb_ld_rd_i == id_rs1_i || wb_ld_rd_i == id_rs2_i ||
                                    wb_ld_rd_i == id_rd_i)) ||
                     (w_is_sw && wb_ld_rd_i == id_rs2_i));

  assign w_sw_wdata = $signed(w_op_b) >>> id_rd_i;

  // Sign-extended halves: the low 32 bits of the product are then the signed product
  assign w_a_lo = {{16{w_op_a[15]}}, w_op_a[15:0]};
  assign w_a_hi = {{16{w_op_a[31]}}, w_op_a[31:16]};
  assign w_b_lo = {{16{w_op_b[15]}}, w_op_b[15:0]};
  assign w_b_hi = {{16{w_op_b[31]}}, w_op_b[31:16]};
  assign w_p0   = w_a_lo * w_b_lo;
  assign w_p1   = w_a_hi * w_b_hi;
  assign w_res  = r_acc + r_p0 + r_p1;

  // Memory request: live from ID in IDLE, frozen copy while waiting in MEM
  always_comb begin
    w_req_valid = 1'b0;
    w_req_addr  = id_base_i;
    w_req_we    = w_is_sw;
    w_req_wdata = w_is_sw ? w_sw_wdata : '0;
    w_req_id    = id_id_i;
    if (r_state == S_MEM) begin
      w_req_valid = 1'b1;
      w_req_addr  = r_req_addr;
      w_req_we    = r_req_we;
      w_req_wdata = r_req_wdata;
      w_req_id    = r_req_id;
    end else if (r_state == S_IDLE && w_is_mem && !w_hazard && !clear_i) begin
      w_req_valid = 1'b1;
    end
  end

  assign mem_valid_o = w_req_valid & rst_ni;
  assign mem_addr_o  = w_req_addr;
  assign mem_we_o    = w_req_we;
  assign mem_be_o    = 4'hF;
  assign mem_wdata_o = w_req_wdata;
  assign mem_id_o    = w_req_id;

  // Record emitted for the instruction currently held in ID
  always_comb begin
    w_rec            = '0;
    w_rec.valid      = 1'b1;
    w_rec.instr      = id_instr_i;
    w_rec.id         = id_id_i;
    w_rec.rd         = id_rd_i;
    w_rec.xrf_we     = w_is_dotp;
    w_rec.xrf_wdata  = w_is_dotp ? ((r_state == S_WB_WAIT) ? r_res : w_res) : '0;
    w_rec.core_we    = w_is_mem;
    w_rec.core_rd    = w_is_mem ? id_rs1_i : '0;
    w_rec.core_wdata = w_is_mem ? (id_base_i + id_offset_i) : '0;
  end

  // Next-state and control decode
  always_comb begin
    w_state_d   = r_state;
    w_emit      = 1'b0;
    w_ready     = 1'b0;
    w_clr       = 1'b0;
    w_load_mul  = 1'b0;
    w_load_req  = 1'b0;
    w_store_res = 1'b0;
    w_kill_d    = r_kill;
    case (r_state)
      S_IDLE: begin
        if (clear_i) begin
          w_clr   = 1'b1;
          w_ready = 1'b1;
        end else if (id_instr_i == I_NONE) begin
          w_ready = 1'b1;
        end else if (w_hazard) begin
          w_ready = 1'b0;
        end else if (w_is_mem) begin
          if (mem_ready_i && wb_ready_i) begin
            w_emit  = 1'b1;
            w_ready = 1'b1;
          end else if (mem_ready_i) begin
            // handshake already taken; only WB is busy, so do not re-issue
            w_state_d = S_WB_WAIT;
          end else begin
            w_load_req = 1'b1;
            w_state_d  = S_MEM;
          end
        end else begin
          w_load_mul = 1'b1;
          w_state_d  = S_MUL;
        end
      end
      S_MEM: begin
        if (clear_i) w_kill_d = 1'b1;
        if (mem_ready_i) begin
          if (clear_i || r_kill) begin
            w_ready   = 1'b1;
            w_kill_d  = 1'b0;
            w_state_d = S_IDLE;
          end else if (wb_ready_i) begin
            w_emit    = 1'b1;
            w_ready   = 1'b1;
            w_state_d = S_IDLE;
          end else begin
            w_state_d = S_WB_WAIT;
          end
        end
      end
      S_MUL: begin
        if (clear_i) begin
          w_clr     = 1'b1;
          w_ready   = 1'b1;
          w_state_d = S_IDLE;
        end else if (wb_ready_i) begin
          w_emit    = 1'b1;
          w_ready   = 1'b1;
          w_state_d = S_IDLE;
        end else begin
          w_store_res = 1'b1;
          w_state_d   = S_WB_WAIT;
        end
      end
      default: begin
        if (clear_i) begin
          w_clr     = 1'b1;
          w_ready   = 1'b1;
          w_state_d = S_IDLE;
        end else if (wb_ready_i) begin
          w_emit    = 1'b1;
          w_ready   = 1'b1;
          w_state_d = S_IDLE;
        end
      end
    endcase
  end

  assign ready_o = w_ready;

  // FSM state, kill flag and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_kill      <= 1'b0;
      r_p0        <= '0;
      r_p1        <= '0;
      r_acc       <= '0;
      r_res       <= '0;
      r_req_addr  <= '0;
      r_req_we    <= 1'b0;
      r_req_wdata <= '0;
      r_req_id    <= '0;
    end else begin
      r_state <= w_state_d;
      r_kill  <= w_kill_d;
      if (w_clr) begin
        r_p0  <= '0;
        r_p1  <= '0;
        r_acc <= '0;
      end else if (w_load_mul) begin
        r_p0  <= w_p0;
        r_p1  <= w_p1;
        r_acc <= w_op_c;
      end
      if (w_store_res) r_res <= w_res;
      if (w_load_req) begin
        r_req_addr  <= w_req_addr;
        r_req_we    <= w_req_we;
        r_req_wdata <= w_req_wdata;
        r_req_id    <= w_req_id;
      end
    end
  end

  // EX/WB record: cleared on flush, otherwise advances only when WB accepts
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rec <= '0;
    end else if (w_clr) begin
      r_rec <= '0;
    end else if (wb_ready_i) begin
      r_rec <= w_emit ? w_rec : '0;
    end
  end

  assign ex2wb_valid_o      = r_rec.valid;
  assign ex2wb_instr_o      = r_rec.instr;
  assign ex2wb_id_o         = r_rec.id;
  assign ex2wb_rd_o         = r_rec.rd;
  assign ex2wb_xrf_we_o     = r_rec.xrf_we;
  assign ex2wb_xrf_wdata_o  = r_rec.xrf_wdata;
  assign ex2wb_core_we_o    = r_rec.core_we;
  assign ex2wb_core_rd_o    = r_rec.core_rd;
  assign ex2wb_core_wdata_o = r_rec.core_wdata;

endmodule
